// File: rtl/logic_unit_pkg.sv
// Shared encodings for the sequential rotate/shift/bit unit: op classes,
// FSM states and flag bit positions.
package logic_unit_pkg;

    // i_Opcode[2:0] shift/rotate selectors when i_Opcode[4:3] == 2'b00
    localparam logic [2:0] SH_RLC  = 3'd0;
    localparam logic [2:0] SH_RRC  = 3'd1;
    localparam logic [2:0] SH_RL   = 3'd2;
    localparam logic [2:0] SH_RR   = 3'd3;
    localparam logic [2:0] SH_SLA  = 3'd4;
    localparam logic [2:0] SH_SRA  = 3'd5;
    localparam logic [2:0] SH_SWAP = 3'd6;
    localparam logic [2:0] SH_SRL  = 3'd7;

    // i_Opcode[4:3] classes; RES/SET share bit 4, bit 3 picks the value
    localparam logic [1:0] CL_SHIFT = 2'b00;
    localparam logic [1:0] CL_BIT   = 2'b01;
    localparam logic [1:0] CL_RES   = 2'b10;
    localparam logic [1:0] CL_SET   = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_H = 1;
    localparam int FLAG_C = 0;

    // Multi-step ops: every shift/rotate except SWAP
    function automatic logic is_multi_step(input logic [4:0] op);
        return (op[4:3] == CL_SHIFT) && (op[2:0] != SH_SWAP);
    endfunction

endpackage

// File: rtl/seq_logic_unit_if.sv
// Request/result bundle for seq_logic_unit; master drives requests and
// takes results, slave is the unit itself.
interface seq_logic_unit_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
);
    localparam int IDX_W = $clog2(WIDTH);

    logic             i_Valid;
    logic             o_Ready;
    logic [WIDTH-1:0] i_A;
    logic [3:0]       i_F;
    logic [4:0]       i_Opcode;
    logic [IDX_W-1:0] i_Index;
    logic [CNT_W-1:0] i_Count;
    logic             i_Disable_Z;
    logic             i_Abort;
    logic             o_Valid;
    logic             i_Ready;
    logic [WIDTH-1:0] o_A;
    logic [3:0]       o_F;

    modport master (
        output i_Valid, i_A, i_F, i_Opcode, i_Index, i_Count, i_Disable_Z,
               i_Abort, i_Ready,
        input  o_Ready, o_Valid, o_A, o_F
    );

    modport slave (
        input  i_Valid, i_A, i_F, i_Opcode, i_Index, i_Count, i_Disable_Z,
               i_Abort, i_Ready,
        output o_Ready, o_Valid, o_A, o_F
    );
endinterface

// File: rtl/logic_shift_step.sv
// One-bit rotate/shift step: value and carry in, value and carry out.
// SWAP is included so the chain is total over all 3-bit selectors.
module logic_shift_step
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] val_in,
    input  logic             c_in,
    output logic [WIDTH-1:0] val_out,
    output logic             c_out
);
    localparam int HALF = WIDTH / 2;

    always_comb begin
        val_out = val_in;
        c_out   = 1'b0;
        case (op)
            SH_RLC:  begin val_out = {val_in[WIDTH-2:0], val_in[WIDTH-1]}; c_out = val_in[WIDTH-1]; end
            SH_RRC:  begin val_out = {val_in[0], val_in[WIDTH-1:1]};       c_out = val_in[0];       end
            SH_RL:   begin val_out = {val_in[WIDTH-2:0], c_in};            c_out = val_in[WIDTH-1]; end
            SH_RR:   begin val_out = {c_in, val_in[WIDTH-1:1]};            c_out = val_in[0];       end
            SH_SLA:  begin val_out = {val_in[WIDTH-2:0], 1'b0};            c_out = val_in[WIDTH-1]; end
            SH_SRA:  begin val_out = {val_in[WIDTH-1], val_in[WIDTH-1:1]}; c_out = val_in[0];       end
            SH_SWAP: begin val_out = {val_in[HALF-1:0], val_in[WIDTH-1:HALF]}; end
            SH_SRL:  begin val_out = {1'b0, val_in[WIDTH-1:1]};            c_out = val_in[0];       end
            default: begin val_out = val_in; c_out = 1'b0; end
        endcase
    end
endmodule

// File: rtl/seq_logic_unit.sv
// Sequential CB-style rotate/shift/BIT/RES/SET unit with valid/ready result.
// LOGIC_UNIT_BARREL_EN: chains all shift steps so every op takes one EXEC cycle.
module seq_logic_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input logic              i_Clk,
    input logic              i_Reset,
    seq_logic_unit_if.slave  bus
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam int HALF  = WIDTH / 2;

    state_t           state;
    logic [WIDTH-1:0] w_a;
    logic             w_c;
    logic [3:0]       f_q;
    logic [4:0]       op_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] rem;
    logic             dz_q;
    logic [WIDTH-1:0] out_a, del_a;
    logic [3:0]       out_f, del_f;

    logic [WIDTH-1:0] stp_a;
    logic             stp_c;
    logic             last_step;
    logic [WIDTH-1:0] res_a;
    logic [3:0]       res_f;
    logic [WIDTH-1:0] swp;

`ifdef LOGIC_UNIT_BARREL_EN
    localparam int MAXN = (1 << CNT_W) - 1;
    logic [MAXN:0][WIDTH-1:0] ch_a;
    logic [MAXN:0]            ch_c;

    assign ch_a[0] = w_a;
    assign ch_c[0] = w_c;
    for (genvar k = 0; k < MAXN; k++) begin : g_chain
        logic_shift_step #(.WIDTH(WIDTH)) u_step (
            .op      (op_q[2:0]),
            .val_in  (ch_a[k]),
            .c_in    (ch_c[k]),
            .val_out (ch_a[k+1]),
            .c_out   (ch_c[k+1])
        );
    end
    // rem holds max(count,1) and is never decremented in this mode
    assign stp_a     = ch_a[rem];
    assign stp_c     = ch_c[rem];
    assign last_step = 1'b1;
`else
    logic_shift_step #(.WIDTH(WIDTH)) u_step (
        .op      (op_q[2:0]),
        .val_in  (w_a),
        .c_in    (w_c),
        .val_out (stp_a),
        .c_out   (stp_c)
    );
    assign last_step = !is_multi_step(op_q) || (rem == CNT_W'(1));
`endif

    assign swp = {w_a[HALF-1:0], w_a[WIDTH-1:HALF]};

    always_comb begin
        res_a         = stp_a;
        res_f         = '0;
        res_f[FLAG_Z] = (stp_a == '0) && !dz_q;
        res_f[FLAG_C] = stp_c;
        if (op_q[4]) begin
            res_a        = w_a;
            res_a[idx_q] = op_q[3];
            res_f        = f_q;
        end else if (op_q[4:3] == CL_BIT) begin
            res_a         = w_a;
            res_f         = '0;
            res_f[FLAG_Z] = !w_a[idx_q];
            res_f[FLAG_H] = 1'b1;
            res_f[FLAG_C] = f_q[FLAG_C];
        end else if (op_q[2:0] == SH_SWAP) begin
            res_a         = swp;
            res_f         = '0;
            res_f[FLAG_Z] = (swp == '0);
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state <= ST_IDLE;
            w_a   <= '0;
            w_c   <= 1'b0;
            f_q   <= '0;
            op_q  <= '0;
            idx_q <= '0;
            rem   <= '0;
            dz_q  <= 1'b0;
            out_a <= '0;
            out_f <= '0;
            del_a <= '0;
            del_f <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_Valid && !bus.i_Abort) begin
                        w_a   <= bus.i_A;
                        w_c   <= bus.i_F[FLAG_C];
                        f_q   <= bus.i_F;
                        op_q  <= bus.i_Opcode;
                        idx_q <= bus.i_Index;
                        rem   <= (bus.i_Count == '0) ? CNT_W'(1) : bus.i_Count;
                        dz_q  <= bus.i_Disable_Z;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (bus.i_Abort) begin
                        rem   <= '0;
                        state <= ST_IDLE;
                    end else if (last_step) begin
                        out_a <= res_a;
                        out_f <= res_f;
                        rem   <= '0;
                        state <= ST_DONE;
                    end else begin
                        w_a <= stp_a;
                        w_c <= stp_c;
                        rem <= rem - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    // abort withdraws the pending result, so fall back to the last one taken
                    if (bus.i_Abort) begin
                        out_a <= del_a;
                        out_f <= del_f;
                        state <= ST_IDLE;
                    end else if (bus.i_Ready) begin
                        del_a <= out_a;
                        del_f <= out_f;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_Ready = (state == ST_IDLE);
    assign bus.o_Valid = (state == ST_DONE);
    assign bus.o_A     = out_a;
    assign bus.o_F     = out_f;

endmodule

// File: tb/tb_seq_logic_unit.sv
// Directed + random bench for seq_logic_unit against an arithmetic reference model.
module tb_seq_logic_unit;
`ifdef LOGIC_UNIT_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [7:0] last_a = 8'h00;
    logic [3:0] last_f = 4'h0;

    always #5 clk = ~clk;

    seq_logic_unit_if #(.WIDTH(8), .CNT_W(3)) bus();

    seq_logic_unit #(.WIDTH(8), .CNT_W(3)) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: results from the op definitions using integer arithmetic
    task automatic model(input logic [4:0] op, input logic [7:0] a, input logic [3:0] f,
                         input logic [2:0] idx, input logic [2:0] cnt, input logic dz,
                         output int ra, output int rf, output int lat);
        int v, c, n, o;
        v = a; c = f[0]; n = (cnt == 0) ? 1 : cnt; lat = 1;
        if (op[4]) begin
            ra = op[3] ? ((a | (1 << idx)) & 255) : (a & ~(1 << idx) & 255);
            rf = f;
        end else if (op[3]) begin
            ra = a;
            rf = ((((a >> idx) & 1) != 0) ? 0 : 8) | 2 | f[0];
        end else if (op[2:0] == 3'd6) begin
            ra = ((a << 4) | (a >> 4)) & 255;
            rf = (ra == 0) ? 8 : 0;
        end else begin
            for (int s = 0; s < n; s++) begin
                case (op[2:0])
                    3'd0:    begin o = v / 128; v = (v * 2 + o) % 256; end
                    3'd1:    begin o = v % 2;   v = v / 2 + o * 128; end
                    3'd2:    begin o = v / 128; v = (v * 2 + c) % 256; end
                    3'd3:    begin o = v % 2;   v = v / 2 + c * 128; end
                    3'd4:    begin o = v / 128; v = (v * 2) % 256; end
                    3'd5:    begin o = v % 2;   v = v / 2 + (v / 128) * 128; end
                    default: begin o = v % 2;   v = v / 2; end
                endcase
                c = o;
            end
            ra  = v;
            rf  = ((v == 0 && !dz) ? 8 : 0) | c;
            lat = BARREL ? 1 : n;
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [7:0] a, input logic [3:0] f,
                         input logic [2:0] idx, input logic [2:0] cnt, input logic dz);
        bus.i_Opcode = op; bus.i_A = a; bus.i_F = f;
        bus.i_Index = idx; bus.i_Count = cnt; bus.i_Disable_Z = dz;
    endtask

    task automatic scramble();
        drive(5'($urandom), 8'($urandom), 4'($urandom), 3'($urandom), 3'($urandom), 1'($urandom));
    endtask

    task automatic do_op(input string tag, input logic [4:0] op, input logic [7:0] a,
                         input logic [3:0] f, input logic [2:0] idx, input logic [2:0] cnt,
                         input logic dz, input int hold);
        int ea, ef, en, lat;
        model(op, a, f, idx, cnt, dz, ea, ef, en);
        @(negedge clk);
        drive(op, a, f, idx, cnt, dz);
        bus.i_Valid = 1'b1; bus.i_Ready = 1'b0;
        @(posedge clk); #1;
        bus.i_Valid = 1'b0;
        scramble();
        chk({tag, "_busy"}, bus.o_Ready, 0);
        lat = 0;
        while (!bus.o_Valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, en);
        chk({tag, "_a"}, bus.o_A, ea);
        chk({tag, "_f"}, bus.o_F, ef);
        bus.i_Valid = 1'b1;
        for (int h = 0; h < hold; h++) begin
            scramble();
            @(posedge clk); #1;
            chk({tag, "_hold_v"}, bus.o_Valid, 1);
            chk({tag, "_hold_a"}, bus.o_A, ea);
            chk({tag, "_hold_f"}, bus.o_F, ef);
        end
        bus.i_Valid = 1'b0; bus.i_Ready = 1'b1;
        @(posedge clk); #1;
        bus.i_Ready = 1'b0;
        chk({tag, "_drop"}, bus.o_Valid, 0);
        chk({tag, "_rdy"}, bus.o_Ready, 1);
        last_a = 8'(ea); last_f = 4'(ef);
    endtask

    initial begin
        bus.i_Valid = 1'b0; bus.i_Ready = 1'b0; bus.i_Abort = 1'b0;
        drive(5'd0, 8'd0, 4'd0, 3'd0, 3'd0, 1'b0);
        #2;
        chk("rst_rdy", bus.o_Ready, 1);
        chk("rst_v", bus.o_Valid, 0);
        chk("rst_a", bus.o_A, 0);
        chk("rst_f", bus.o_F, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_rdy", bus.o_Ready, 1);

        do_op("rlc",    5'b00000, 8'h85, 4'h0, 3'd0, 3'd1, 1'b0, 0);
        do_op("rl3",    5'b00010, 8'h80, 4'h0, 3'd0, 3'd3, 1'b0, 1);
        do_op("sra2",   5'b00101, 8'h81, 4'h0, 3'd0, 3'd2, 1'b0, 0);
        do_op("srl",    5'b00111, 8'h01, 4'h0, 3'd0, 3'd1, 1'b0, 0);
        do_op("srl_dz", 5'b00111, 8'h01, 4'h0, 3'd0, 3'd1, 1'b1, 0);
        do_op("bit7",   5'b01101, 8'h7F, 4'h1, 3'd7, 3'd0, 1'b0, 0);
        do_op("set0",   5'b11010, 8'h00, 4'h5, 3'd0, 3'd4, 1'b0, 0);
        do_op("res3",   5'b10000, 8'hFF, 4'hA, 3'd3, 3'd0, 1'b0, 0);
        do_op("swap",   5'b00110, 8'hA5, 4'hF, 3'd0, 3'd7, 1'b0, 0);
        do_op("sla_c0", 5'b00100, 8'hC3, 4'h0, 3'd0, 3'd0, 1'b0, 0);
        do_op("rrc7",   5'b00001, 8'h96, 4'h0, 3'd0, 3'd7, 1'b0, 0);
        do_op("rr_hold",5'b00011, 8'h5A, 4'h1, 3'd0, 3'd5, 1'b0, 4);

        // abort on the second EXEC cycle
        @(negedge clk);
        drive(5'b00011, 8'h3C, 4'h1, 3'd0, 3'd5, 1'b0);
        bus.i_Valid = 1'b1;
        @(posedge clk); #1;
        bus.i_Valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_pre_v", bus.o_Valid, BARREL);
        bus.i_Abort = 1'b1;
        @(posedge clk); #1;
        bus.i_Abort = 1'b0;
        chk("abort_rdy", bus.o_Ready, 1);
        chk("abort_v", bus.o_Valid, 0);
        chk("abort_a", bus.o_A, last_a);
        chk("abort_f", bus.o_F, last_f);
        repeat (6) begin
            @(posedge clk); #1;
            chk("abort_idle_v", bus.o_Valid, 0);
        end

        // reset in the middle of an operation
        @(negedge clk);
        drive(5'b00011, 8'h3C, 4'h1, 3'd0, 3'd5, 1'b0);
        bus.i_Valid = 1'b1;
        @(posedge clk); #1;
        bus.i_Valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mrst_a", bus.o_A, 0);
        chk("mrst_f", bus.o_F, 0);
        chk("mrst_v", bus.o_Valid, 0);
        chk("mrst_rdy", bus.o_Ready, 1);
        @(negedge clk);
        rst = 1'b0;
        last_a = 8'h00; last_f = 4'h0;
        repeat (6) begin
            @(posedge clk); #1;
            chk("mrst_idle_v", bus.o_Valid, 0);
        end

        // abort alongside valid in IDLE blocks the accept
        @(negedge clk);
        drive(5'b00000, 8'h11, 4'h0, 3'd0, 3'd1, 1'b0);
        bus.i_Valid = 1'b1; bus.i_Abort = 1'b1;
        @(posedge clk); #1;
        bus.i_Valid = 1'b0; bus.i_Abort = 1'b0;
        chk("idle_abort_rdy", bus.o_Ready, 1);
        @(posedge clk); #1;
        chk("idle_abort_v", bus.o_Valid, 0);

        for (int r = 0; r < 60; r++) begin
            do_op("rnd", 5'($urandom), 8'($urandom), 4'($urandom), 3'($urandom),
                  3'($urandom), 1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
